pool_flatten: RTL and testbench
===============================

POOL_FLATTEN -- requirements
Module: pool_flatten

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port start, input, 1 bit: begin one full pooling and flatten pass; sampled only in IDLE.
REQ-004 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until the pass completes.
REQ-005 SHALL have port crd, output, 1 bit: read strobe to the layer memories.
REQ-006 SHALL have port caddr_rd, output, 12 bits: read address.
REQ-007 SHALL have port cdata_rd, input, 20 bits: read data, valid at the rising edge following the crd cycle.
REQ-008 SHALL have port cwr, output, 1 bit: write strobe.
REQ-009 SHALL have port caddr_wr, output, 12 bits: write address.
REQ-010 SHALL have port cdata_wr, output, 20 bits: write data.
REQ-011 SHALL have port csel, output, 3 bits: memory select; 001 = L0 kernel0, 010 = L0 kernel1, 011 = L1 kernel0, 100 = L1 kernel1, 101 = L2.

Function
REQ-012 SHALL read from the 64x64 L0 maps and write the 32x32 L1 maps plus the 2048-word interleaved L2 flatten memory.
REQ-013 SHALL process kernel k=0 for all 1024 outputs, then k=1; outputs in raster order, r=0..31 outer, c=0..31 inner.
REQ-014 SHALL, per output (r,c), read L0 addresses base, base+1, base+64, base+65, in that order, where base = r*128 + c*2.
REQ-015 SHALL use csel=001 for L0 reads when k=0 and csel=010 when k=1.
REQ-016 SHALL compute the 2x2 maximum as an unsigned 20-bit compare; on equal values either operand is acceptable because the results are identical.
REQ-017 SHALL write the maximum to L1 at address r*32+c, with csel=011 for k=0 and 100 for k=1.
REQ-018 SHALL then write the same value to L2 at address (r*32+c)*2+k with csel=101.
REQ-019 SHALL implement the FSM states IDLE, RD0, RD1, RD2, RD3, CMP, WL1, WL2, DONE.
REQ-020 SHALL follow these transitions:
- IDLE->RD0 on start=1.
- RDn->RDn+1; RD3->CMP->WL1->WL2.
- WL2->RD0 if more outputs remain, else WL2->DONE.
- DONE->IDLE.
REQ-021 SHALL assert crd with a valid caddr_rd only in RD0..RD3.
REQ-022 SHALL capture cdata_rd at the rising edge that ends RD1, RD2, RD3 and CMP (the read issued in the prior state).
REQ-023 SHALL assert cwr only in WL1 and WL2, and SHALL never assert crd and cwr in the same cycle.
REQ-024 SHALL hold csel stable for each access cycle; csel=000 in IDLE and DONE.
REQ-025 SHALL take exactly 7 cycles per output; a full pass is 2048*7 = 14336 cycles from the first RD0 to the last WL2.
REQ-026 SHALL set busy=1 in every state except IDLE; busy falls on entry to IDLE after DONE.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL wrap counters at the boundaries: c=31 -> c=0 with r+1; r=31,c=31 -> kernel+1; kernel 1 at the last output -> DONE.
REQ-029 SHALL hold crd, cwr and the addresses at 0 in IDLE and DONE.

Reset
REQ-030 SHALL, while reset=0, force state=IDLE, busy=0, crd=0, cwr=0, csel=000, caddr_rd=0, caddr_wr=0, cdata_wr=0, counters=0 and the max register=0.
REQ-031 SHALL, on reset asserted mid-pass, abort immediately with no further reads or writes.
REQ-032 SHALL, after reset is released, require a new start; there is no resume of the aborted pass.

Verification
REQ-033 SHALL be covered by this scenario: both L0 maps all zero, start -> 1024+1024 L1 words = 0, 2048 L2 words = 0, busy high for 14336+2 cycles.
REQ-034 SHALL be covered by this scenario: L0k0[addr]=addr, L0k1[addr]=4095-addr -> L1k0[r*32+c]=r*128+c*2+65; L1k1[r*32+c]=4095-(r*128+c*2); L2 interleaves those values.
REQ-035 SHALL be covered by this scenario: corner output r=31,c=31, k=1 -> reads 4030, 4031, 4094, 4095 with csel=010; writes L1 addr 1023 (csel=100) and L2 addr 2047.
REQ-036 SHALL be covered by this scenario: window values 0xFFFFF, 0x00001, 0x80000, 0x7FFFF -> output 0xFFFFF (unsigned compare).
REQ-037 SHALL be covered by this scenario: reset=0 asserted during the WL1 of output 100 -> no cwr that cycle or after, all outputs 0; a new start rewrites from address 0.
REQ-038 SHALL be covered by this scenario: start pulsed again while busy -> no restart; total cycles and the write count (4096) unchanged.

Source files
------------

// File: rtl/pool_flatten.sv
// pool_flatten: 2x2 max-pooling of two 64x64 L0 feature maps into two 32x32
// L1 maps, with every pooled value also written to an interleaved L2
// flatten memory at (r*32+c)*2+k.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; all strobes, addresses and csel at 0
// RD0   | read top-left pixel of the 2x2 window
// RD1   | read top-right pixel; capture top-left
// RD2   | read bottom-left pixel; capture top-right
// RD3   | read bottom-right pixel; capture bottom-left
// CMP   | capture bottom-right; max register now final after this edge
// WL1   | write max to L1 kernel map at r*32+c
// WL2   | write max to L2 at (r*32+c)*2+k; advance output counters
// DONE  | pass finished; one cycle before returning to IDLE
module pool_flatten (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic [2:0]  csel
);

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        CMP,
        WL1,
        WL2,
        DONE
    } state_t;

    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam logic [2:0] SEL_L0_K0 = 3'b001;
    localparam logic [2:0] SEL_L0_K1 = 3'b010;
    localparam logic [2:0] SEL_L1_K0 = 3'b011;
    localparam logic [2:0] SEL_L1_K1 = 3'b100;
    localparam logic [2:0] SEL_L2    = 3'b101;

    state_t      state_q;
    state_t      state_d;
    logic        kern_q;
    logic [4:0]  row_q;
    logic [4:0]  col_q;
    logic [19:0] max_q;
    logic        last_out;
    logic [2:0]  sel_l0;
    logic [2:0]  sel_l1;

    // Last output of the whole pass: kernel 1, bottom-right corner.
    assign last_out = kern_q & (&row_q) & (&col_q);
    assign sel_l0   = kern_q ? SEL_L0_K1 : SEL_L0_K0;
    assign sel_l1   = kern_q ? SEL_L1_K1 : SEL_L1_K0;

    // State register; an asserted reset aborts any pass in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed 7-cycle sequence per output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD0;
            RD0:     state_d = RD1;
            RD1:     state_d = RD2;
            RD2:     state_d = RD3;
            RD3:     state_d = CMP;
            CMP:     state_d = WL1;
            WL1:     state_d = WL2;
            WL2:     state_d = last_out ? DONE : RD0;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output position counters; the 5-bit fields wrap naturally so the
    // final advance leaves them all at zero for the next pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kern_q <= 1'b0;
            row_q  <= 5'd0;
            col_q  <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        kern_q <= 1'b0;
                        row_q  <= 5'd0;
                        col_q  <= 5'd0;
                    end
                end
                WL2: begin
                    col_q <= col_q + 5'd1;
                    if (&col_q) begin
                        row_q <= row_q + 5'd1;
                        if (&row_q) begin
                            kern_q <= ~kern_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Running maximum: read data arrives one cycle after each strobe, so
    // the first pixel is loaded at the end of RD1 and compared thereafter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= 20'd0;
        end else begin
            case (state_q)
                RD1: max_q <= cdata_rd;
                RD2, RD3, CMP: begin
                    if (cdata_rd > max_q) begin
                        max_q <= cdata_rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobes and addresses decoded from state; the L0 address is
    // {row, dy, col, dx}, i.e. r*128 + c*2 + dy*64 + dx.
    always_comb begin
        busy     = (state_q != IDLE);
        crd      = 1'b0;
        cwr      = 1'b0;
        caddr_rd = 12'd0;
        caddr_wr = 12'd0;
        cdata_wr = 20'd0;
        csel     = SEL_NONE;
        case (state_q)
            RD0: begin
                crd      = 1'b1;
                caddr_rd = {row_q, 1'b0, col_q, 1'b0};
                csel     = sel_l0;
            end
            RD1: begin
                crd      = 1'b1;
                caddr_rd = {row_q, 1'b0, col_q, 1'b1};
                csel     = sel_l0;
            end
            RD2: begin
                crd      = 1'b1;
                caddr_rd = {row_q, 1'b1, col_q, 1'b0};
                csel     = sel_l0;
            end
            RD3: begin
                crd      = 1'b1;
                caddr_rd = {row_q, 1'b1, col_q, 1'b1};
                csel     = sel_l0;
            end
            WL1: begin
                cwr      = 1'b1;
                caddr_wr = {2'b00, row_q, col_q};
                cdata_wr = max_q;
                csel     = sel_l1;
            end
            WL2: begin
                cwr      = 1'b1;
                caddr_wr = {row_q, col_q, kern_q};
                cdata_wr = max_q;
                csel     = SEL_L2;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_pool_flatten.sv
// Bench for pool_flatten: L0 memory model, expected-access scoreboard and
// directed passes (all-zero, ramp, reset abort, unsigned corner windows).
module tb_pool_flatten;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd = 20'd0;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic [2:0]  csel;

    logic [19:0] l0k0 [4096];
    logic [19:0] l0k1 [4096];
    logic [34:0] exp_rd [$];
    logic [34:0] exp_wr [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          wr_cnt = 0;

    pool_flatten dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered-read L0 memory model and write counter.
    initial forever begin
        @(posedge clk);
        if (crd) begin
            if (csel == 3'b001)      cdata_rd <= l0k0[caddr_rd];
            else if (csel == 3'b010) cdata_rd <= l0k1[caddr_rd];
            else                     cdata_rd <= 20'h0;
        end
        if (cwr) wr_cnt <= wr_cnt + 1;
    end

    // Monitor: every strobe must match the next expected access.
    initial forever begin
        @(negedge clk);
        if (crd && cwr) begin
            n_err++;
            $display("FAIL rd_wr_overlap: crd=%b cwr=%b expected not both", crd, cwr);
        end
        if (crd) begin
            if (exp_rd.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: sel=%0d addr=%0d expected no read", csel, caddr_rd);
            end else begin
                chk("read", {csel, caddr_rd, 20'h0}, exp_rd.pop_front());
            end
        end
        if (cwr) begin
            if (exp_wr.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: sel=%0d addr=%0d data=%h expected no write", csel, caddr_wr, cdata_wr);
            end else begin
                chk("write", {csel, caddr_wr, cdata_wr}, exp_wr.pop_front());
            end
        end
    end

    function automatic logic [19:0] exp_val(input int kind, input int k, input int r, input int c);
        int b;
        b = r * 128 + c * 2;
        if (kind == 1) return (k == 0) ? 20'(b + 65) : 20'(4095 - b);
        if (kind == 2) begin
            if (k == 0 && r == 0 && c == 0)   return 20'hFFFFF;
            if (k == 0 && r == 5 && c == 7)   return 20'h00009;
            if (k == 1 && r == 31 && c == 31) return 20'h80000;
        end
        return 20'h0;
    endfunction

    task automatic fill_l0(input int kind);
        for (int a = 0; a < 4096; a++) begin
            l0k0[a] = (kind == 1) ? 20'(a) : 20'h0;
            l0k1[a] = (kind == 1) ? 20'(4095 - a) : 20'h0;
        end
        if (kind == 2) begin
            l0k0[0]    = 20'hFFFFF; l0k0[1]    = 20'h00001;
            l0k0[64]   = 20'h80000; l0k0[65]   = 20'h7FFFF;
            l0k0[654]  = 20'h00003; l0k0[655]  = 20'h00001;
            l0k0[718]  = 20'h00002; l0k0[719]  = 20'h00009;
            l0k1[4030] = 20'h7FFFF; l0k1[4031] = 20'h80000;
            l0k1[4094] = 20'h00010; l0k1[4095] = 20'h00000;
        end
    endtask

    task automatic push_pass(input int kind);
        logic [2:0]  rsel;
        logic [19:0] v;
        int          b;
        int          o;
        for (int k = 0; k < 2; k++) begin
            rsel = (k == 0) ? 3'b001 : 3'b010;
            for (int r = 0; r < 32; r++) begin
                for (int c = 0; c < 32; c++) begin
                    b = r * 128 + c * 2;
                    o = r * 32 + c;
                    exp_rd.push_back({rsel, 12'(b),      20'h0});
                    exp_rd.push_back({rsel, 12'(b + 1),  20'h0});
                    exp_rd.push_back({rsel, 12'(b + 64), 20'h0});
                    exp_rd.push_back({rsel, 12'(b + 65), 20'h0});
                    v = exp_val(kind, k, r, c);
                    exp_wr.push_back({(k == 0) ? 3'b011 : 3'b100, 12'(o), v});
                    exp_wr.push_back({3'b101, 12'(o * 2 + k), v});
                end
            end
        end
    endtask

    // One full pass: edges from start acceptance until busy is seen low
    // again covers 14336 working cycles, DONE, and the accepting edge.
    task automatic run_pass(input int kind, input bit pulse_again);
        int span;
        int wr_base;
        fill_l0(kind);
        push_pass(kind);
        wr_base = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        span = 1;
        chk("busy_rise", 35'(busy), 35'(1));
        while (busy && span < 20000) begin
            @(posedge clk);
            #1;
            span++;
            start = (pulse_again && (span == 500 || span == 9000)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("busy_span", 35'(span), 35'(14338));
        chk("write_count", 35'(wr_cnt - wr_base), 35'(4096));
        chk("rd_queue_left", 35'(exp_rd.size()), 35'(0));
        chk("wr_queue_left", 35'(exp_wr.size()), 35'(0));
        exp_rd.delete();
        exp_wr.delete();
    endtask

    initial begin
        int wr_base;
        int guard;

        // Outputs while held in reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",     35'(busy),     35'(0));
        chk("rst_crd",      35'(crd),      35'(0));
        chk("rst_cwr",      35'(cwr),      35'(0));
        chk("rst_csel",     35'(csel),     35'(0));
        chk("rst_caddr_rd", 35'(caddr_rd), 35'(0));
        chk("rst_caddr_wr", 35'(caddr_wr), 35'(0));
        chk("rst_cdata_wr", 35'(cdata_wr), 35'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 35'(busy), 35'(0));

        // All-zero maps.
        run_pass(0, 1'b0);
        // Ramp maps, with start pulsed twice while busy.
        run_pass(1, 1'b1);

        // Abort during WL1 of output 100 (k=0): 200 writes must have landed.
        fill_l0(1);
        push_pass(1);
        wr_base = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(cwr && (wr_cnt - wr_base) == 200) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("abort_reached", 35'(guard < 2000), 35'(1));
        reset = 1'b0;
        #1;
        exp_rd.delete();
        exp_wr.delete();
        chk("abort_cwr",   35'(cwr),  35'(0));
        chk("abort_crd",   35'(crd),  35'(0));
        chk("abort_busy",  35'(busy), 35'(0));
        chk("abort_csel",  35'(csel), 35'(0));
        chk("abort_cdata", 35'(cdata_wr), 35'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("abort_writes", 35'(wr_cnt - wr_base), 35'(200));
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_resume_busy",   35'(busy), 35'(0));
        chk("no_resume_writes", 35'(wr_cnt - wr_base), 35'(200));

        // Fresh pass after abort with unsigned corner windows.
        run_pass(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
